// File: rtl/led_sched_pkg.sv
// Shared types and helpers for the LED source scheduler: controller states,
// source count and the round-robin winner selection.
package led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } sched_state_e;

  localparam int NUM_SRC = 4;

  // Lowest offset from last+1 wins; index last itself is tried last.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] req);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) begin
        rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// One push switch: two-flop synchronizer, stability counter and a single-cycle
// pulse in the first cycle the debounced level reads high.
module switch_debounce #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             rise_r;
  logic [CNT_W-1:0] cnt_r;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // Level flips only after DEBOUNCE_LIMIT consecutive disagreeing cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_r <= 1'b0;
      rise_r  <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (sync2_r != level_r) begin
      if (cnt_r == CNT_LAST) begin
        level_r <= sync2_r;
        rise_r  <= sync2_r;
        cnt_r   <= {CNT_W{1'b0}};
      end else begin
        rise_r  <= 1'b0;
        cnt_r   <= cnt_r + CNT_W'(1);
      end
    end else begin
      rise_r <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/led_source_scheduler.sv
// Round-robin arbiter sharing four LEDs between four fixed source patterns,
// each requested by a debounced push switch and held for a fixed window.
module led_source_scheduler
  import led_sched_pkg::*;
#(
  parameter int         DEBOUNCE_LIMIT = 250000,
  parameter int         HOLD_CYCLES    = 25000000,
  parameter logic [3:0] SRC_0          = 4'b1000,
  parameter logic [3:0] SRC_1          = 4'b0001,
  parameter logic [3:0] SRC_2          = 4'b0110,
  parameter logic [3:0] SRC_3          = 4'b1111
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4,
  output logic [1:0] o_Sel,
  output logic       o_Busy
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  logic [NUM_SRC-1:0] raw_s;
  logic [NUM_SRC-1:0] rise_s;
  logic [NUM_SRC-1:0] clear_s;
  logic [NUM_SRC-1:0] pending_r;
  sched_state_e       state_r;
  sched_state_e       state_s;
  logic [1:0]         last_r;
  logic [1:0]         pick_s;
  logic [1:0]         sel_r;
  logic [3:0]         pattern_s;
  logic [3:0]         led_r;
  logic               busy_r;
  logic [HOLD_W-1:0]  hold_cnt_r;

  assign raw_s = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  for (genvar n = 0; n < NUM_SRC; n++) begin : g_sw
    switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_debounce (
      .clk   (i_Clk),
      .reset (i_Reset),
      .raw   (raw_s[n]),
      .rise  (rise_s[n])
    );
  end

  // Winner and its pattern for the current pending set.
  always_comb begin
    pattern_s = 4'b0000;
    pick_s    = rr_pick(last_r, pending_r);
    case (pick_s)
      2'd0:    pattern_s = SRC_0;
      2'd1:    pattern_s = SRC_1;
      2'd2:    pattern_s = SRC_2;
      2'd3:    pattern_s = SRC_3;
      default: pattern_s = 4'b0000;
    endcase
  end

  // Controller next state and the pending bit retired by a grant.
  always_comb begin
    state_s = state_r;
    clear_s = {NUM_SRC{1'b0}};
    case (state_r)
      IDLE: begin
        if (pending_r != 4'b0000) state_s = GRANT;
        else                      state_s = IDLE;
      end
      GRANT: begin
        state_s = HOLD;
        clear_s = 4'b0001 << pick_s;
      end
      HOLD: begin
        if (hold_cnt_r != {HOLD_W{1'b0}}) state_s = HOLD;
        else if (pending_r != 4'b0000)    state_s = GRANT;
        else                              state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) state_r <= IDLE;
    else         state_r <= state_s;
  end

  // New presses win over a same-cycle clear of the same bit.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) pending_r <= {NUM_SRC{1'b0}};
    else         pending_r <= (pending_r & ~clear_s) | rise_s;
  end

  // Grant datapath: pointer, hold countdown and registered display outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      last_r     <= 2'd3;
      sel_r      <= 2'd0;
      led_r      <= 4'b0000;
      busy_r     <= 1'b0;
      hold_cnt_r <= {HOLD_W{1'b0}};
    end else begin
      busy_r <= (state_r != IDLE);
      if (state_r == GRANT) begin
        last_r     <= pick_s;
        sel_r      <= pick_s;
        led_r      <= pattern_s;
        hold_cnt_r <= HOLD_LOAD;
      end else if ((state_r == HOLD) && (hold_cnt_r != {HOLD_W{1'b0}})) begin
        hold_cnt_r <= hold_cnt_r - HOLD_W'(1);
      end else begin
        hold_cnt_r <= hold_cnt_r;
      end
    end
  end

  assign o_LED_1 = led_r[0];
  assign o_LED_2 = led_r[1];
  assign o_LED_3 = led_r[2];
  assign o_LED_4 = led_r[3];
  assign o_Sel   = sel_r;
  assign o_Busy  = busy_r;

endmodule

// File: tb/tb_led_source_scheduler.sv
// Directed bench for led_source_scheduler: expected grants are queued as each
// stimulus step is driven and a monitor pops them as grants appear on the LEDs.
module tb_led_source_scheduler;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] leds;
  } grant_t;

  logic       clk;
  logic       i_Reset;
  logic [3:0] sw;
  logic       o_LED_1, o_LED_2, o_LED_3, o_LED_4;
  logic [1:0] o_Sel;
  logic       o_Busy;
  logic [3:0] leds_s;

  grant_t sb_q[$];
  int     tests = 0;
  int     fails = 0;

  led_source_scheduler #(
    .DEBOUNCE_LIMIT (4),
    .HOLD_CYCLES    (8),
    .SRC_0          (4'b1000),
    .SRC_1          (4'b0001),
    .SRC_2          (4'b0110),
    .SRC_3          (4'b1111)
  ) dut (
    .i_Clk      (clk),
    .i_Reset    (i_Reset),
    .i_Switch_1 (sw[0]),
    .i_Switch_2 (sw[1]),
    .i_Switch_3 (sw[2]),
    .i_Switch_4 (sw[3]),
    .o_LED_1    (o_LED_1),
    .o_LED_2    (o_LED_2),
    .o_LED_3    (o_LED_3),
    .o_LED_4    (o_LED_4),
    .o_Sel      (o_Sel),
    .o_Busy     (o_Busy)
  );

  assign leds_s = {o_LED_4, o_LED_3, o_LED_2, o_LED_1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] pattern(input logic [1:0] s);
    case (s)
      2'd0:    pattern = 4'b1000;
      2'd1:    pattern = 4'b0001;
      2'd2:    pattern = 4'b0110;
      default: pattern = 4'b1111;
    endcase
  endfunction

  task automatic expect_grant(input logic [1:0] s);
    grant_t g;
    g.sel  = s;
    g.leds = pattern(s);
    sb_q.push_back(g);
  endtask

  task automatic check_outputs(input string tag, input logic [1:0] sel, input logic [3:0] leds, input logic busy);
    check({tag, "_sel"},  {6'b000000, o_Sel}, {6'b000000, sel});
    check({tag, "_leds"}, {4'b0000, leds_s},  {4'b0000, leds});
    check({tag, "_busy"}, {7'b0000000, o_Busy}, {7'b0000000, busy});
  endtask

  // A grant starts when busy rises or when a 9-cycle window rolls straight into the next.
  logic       prev_busy = 1'b0;
  int         run = 0;
  logic       cur_valid = 1'b0;
  logic [3:0] cur_leds = 4'b0000;
  grant_t     exp_g;

  always begin
    @(posedge clk);
    #1;
    if (o_Busy === 1'b1) begin
      if (!prev_busy || run == 9) begin
        check("grant_expected", {7'b0000000, sb_q.size() != 0}, 8'h01);
        if (sb_q.size() != 0) begin
          exp_g = sb_q.pop_front();
          check("grant_sel",  {6'b000000, o_Sel}, {6'b000000, exp_g.sel});
          check("grant_leds", {4'b0000, leds_s},  {4'b0000, exp_g.leds});
          cur_leds  = exp_g.leds;
          cur_valid = 1'b1;
        end else begin
          cur_valid = 1'b0;
        end
        run = 1;
      end else begin
        run++;
        if (cur_valid) check("hold_leds", {4'b0000, leds_s}, {4'b0000, cur_leds});
      end
    end else begin
      run = 0;
    end
    prev_busy = o_Busy;
  end

  initial begin
    i_Reset = 1'b1;
    sw      = 4'b0000;
    step(3);
    check_outputs("reset", 2'd0, 4'b0000, 1'b0);
    i_Reset = 1'b0;
    step(2);

    // Clean press of switch 2: outputs move exactly 9 cycles later, busy for 9.
    expect_grant(2'd1);
    sw = 4'b0010;
    step(8);
    check_outputs("t1_pre", 2'd0, 4'b0000, 1'b0);
    step(1);
    check_outputs("t1_grant", 2'd1, 4'b0001, 1'b1);
    sw = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("t1_busy_hold", {7'b0000000, o_Busy}, 8'h01);
    end
    step(1);
    check_outputs("t1_idle", 2'd1, 4'b0001, 1'b0);
    step(10);

    // Pointer at 1: switches 1,3,4 plus three presses of switch 2 -> 2,3,0,1 once.
    expect_grant(2'd2);
    expect_grant(2'd3);
    expect_grant(2'd0);
    expect_grant(2'd1);
    sw = 4'b1111;
    step(7);
    sw = 4'b0000;
    step(6);
    sw = 4'b0010;
    step(7);
    sw = 4'b0000;
    step(6);
    sw = 4'b0010;
    step(7);
    sw = 4'b0000;
    step(12);
    check_outputs("t5_idle", 2'd1, 4'b0001, 1'b0);
    step(10);
    check_outputs("t5_no_repeat", 2'd1, 4'b0001, 1'b0);

    // Bouncing switch 1 yields a single grant of source 0.
    expect_grant(2'd0);
    for (int i = 0; i < 5; i++) begin
      sw = 4'b0001;
      step(2);
      sw = 4'b0000;
      step(2);
    end
    sw = 4'b0001;
    step(20);
    sw = 4'b0000;
    step(15);
    check_outputs("t2_idle", 2'd0, 4'b1000, 1'b0);

    // Reset, then switches 1,3,4 together: 0,2,3 back to back.
    i_Reset = 1'b1;
    step(1);
    check_outputs("t3_reset", 2'd0, 4'b0000, 1'b0);
    i_Reset = 1'b0;
    step(1);
    expect_grant(2'd0);
    expect_grant(2'd2);
    expect_grant(2'd3);
    sw = 4'b1101;
    step(9);
    sw = 4'b0000;
    for (int i = 0; i < 27; i++) begin
      check("t3_busy_cont", {7'b0000000, o_Busy}, 8'h01);
      step(1);
    end
    check("t3_busy_end", {7'b0000000, o_Busy}, 8'h00);
    step(5);

    // Switch 4 and a second switch-1 press during source 0's hold: 3 then 0.
    expect_grant(2'd2);
    expect_grant(2'd0);
    expect_grant(2'd3);
    expect_grant(2'd0);
    sw = 4'b0100;
    step(2);
    sw = 4'b0101;
    step(7);
    sw = 4'b0000;
    step(5);
    sw = 4'b1000;
    step(2);
    sw = 4'b1001;
    step(30);
    sw = 4'b0000;
    step(12);
    check_outputs("t4_idle", 2'd0, 4'b1000, 1'b0);

    // Reset mid-hold of source 2 drops the pending switch-4 request.
    expect_grant(2'd2);
    sw = 4'b1100;
    step(8);
    sw = 4'b0000;
    step(4);
    i_Reset = 1'b1;
    step(1);
    check_outputs("t6_reset", 2'd0, 4'b0000, 1'b0);
    i_Reset = 1'b0;
    step(25);
    check_outputs("t6_lost", 2'd0, 4'b0000, 1'b0);

    check("sb_drained", 8'(sb_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
